// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared FSM state type, default field constants and index sizing helper for the GF(2^M) power engine.
package gf2m_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int M_DEF = 6;
    localparam int unsigned POLY_DEF = 32'h43;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/gf2m_pow_seq_if.sv
// gf2m_pow_seq_if: operand/result valid-ready bundle between sweep controller, power engine and collector.
interface gf2m_pow_seq_if import gf2m_pkg::*; #(parameter int M = M_DEF);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_x;
    logic [M-1:0] in_e;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_y;
    logic         busy;
    modport slave (input in_valid, in_x, in_e, out_ready, output in_ready, out_valid, out_y, busy);
    modport master (output in_valid, in_x, in_e, out_ready, input in_ready, out_valid, out_y, busy);
endinterface

// File: rtl/gf2m_mul.sv
// gf2m_mul: combinational a*b in GF(2^M), polynomial basis, reduced mod POLY (Horner, MSB of b first).
module gf2m_mul #(
    parameter int          M    = 6,
    parameter int unsigned POLY = 32'h43
) (
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_b,
    output logic [M-1:0] o_p
);
    localparam logic [M-1:0] RED = POLY[M-1:0];
    logic [M-1:0] w_p;
    always_comb begin
        w_p = '0;
        for (int i = M - 1; i >= 0; i--)
            w_p = {w_p[M-2:0], 1'b0} ^ (w_p[M-1] ? RED : '0) ^ (i_b[i] ? i_a : '0);
    end
    assign o_p = w_p;
endmodule

// File: rtl/gf2m_pow_seq.sv
// gf2m_pow_seq: sequential y = x^e in GF(2^M) by left-to-right square-and-multiply, one exponent bit per cycle.
// Optional SMS_AFFINE_OUT_EN XORs a broadcast parity of x[2]^x[4] into the result.
module gf2m_pow_seq import gf2m_pkg::*; #(
    parameter int          M    = M_DEF,
    parameter int unsigned POLY = POLY_DEF
) (
    input logic              clk,
    input logic              rst,
    gf2m_pow_seq_if.slave    bus
);
    localparam int IW = clog2(M);
    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};
    state_t        r_state;
    logic [M-1:0]  r_acc, r_x, r_e, r_y;
    logic [IW-1:0] r_idx;
    logic          r_in_ready, r_out_valid, r_busy;
    logic [M-1:0]  w_sq, w_b, w_mul, w_aff;
    assign w_b = r_e[r_idx] ? r_x : ONE;
`ifdef SMS_AFFINE_OUT_EN
    assign w_aff = {M{r_x[2] ^ r_x[4]}};
`else
    assign w_aff = '0;
`endif
    gf2m_mul #(.M(M), .POLY(POLY)) u_sq  (.i_a(r_acc), .i_b(r_acc), .o_p(w_sq));
    gf2m_mul #(.M(M), .POLY(POLY)) u_mul (.i_a(w_sq),  .i_b(w_b),   .o_p(w_mul));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_y         <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_e         <= '0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_x        <= bus.in_x;
                    r_e        <= bus.in_e;
                    r_acc      <= ONE;
                    r_idx      <= IW'(M - 1);
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                    r_state    <= RUN;
                end
                RUN: begin
                    r_acc <= w_mul;
                    r_idx <= r_idx - IW'(1);
                    if (r_idx == '0) begin
                        r_y         <= w_mul ^ w_aff;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_y     = r_y;
    assign bus.busy      = r_busy;
endmodule
